// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for a 5-stage pipeline: load-use bubbles, branch redirects,
// data-memory wait freezes, a saturating stall counter and a sticky memory-timeout flag.
module pipeline_hazard_ctrl #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [4:0]       id_rs1_i,
  input  logic [4:0]       id_rs2_i,
  input  logic             id_use_rs1_i,
  input  logic             id_use_rs2_i,
  input  logic [4:0]       ex_rd_i,
  input  logic             ex_mem_r_i,
  input  logic             ex_reg_w_i,
  input  logic             branch_taken_i,
  input  logic             mem_req_i,
  input  logic             mem_ready_i,
  output logic             pc_en_o,
  output logic             if_id_en_o,
  output logic             id_ex_en_o,
  output logic             ex_mem_en_o,
  output logic             if_id_flush_o,
  output logic             id_ex_flush_o,
  output logic             mem_wb_flush_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic             mem_err_o
);

  localparam logic [7:0] TimeoutVal = 8'(TIMEOUT);

  typedef enum logic [1:0] {StRun, StMemWait, StFlush} state_e;

  state_e           r_state;
  logic             r_pend_br;
  logic [7:0]       r_wait_cnt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic             r_mem_err;

  logic       w_lu;
  logic       w_ms;
  logic       w_rdy;
  logic       w_freeze;
  logic [7:0] w_wait_nxt;

  assign w_lu = ex_mem_r_i & ex_reg_w_i & (ex_rd_i != 5'd0) &
                ((id_use_rs1_i & (id_rs1_i == ex_rd_i)) |
                 (id_use_rs2_i & (id_rs2_i == ex_rd_i)));
  assign w_ms = mem_req_i & ~mem_ready_i;
  // Dropping the request while waiting abandons the access, same as completion.
  assign w_rdy      = mem_ready_i | ~mem_req_i;
  assign w_freeze   = (r_state == StMemWait) ? ~w_rdy : w_ms;
  assign w_wait_nxt = (r_wait_cnt == 8'hff) ? r_wait_cnt : r_wait_cnt + 8'd1;

  always_comb begin
    pc_en_o        = 1'b1;
    if_id_en_o     = 1'b1;
    id_ex_en_o     = 1'b1;
    ex_mem_en_o    = 1'b1;
    if_id_flush_o  = 1'b0;
    id_ex_flush_o  = 1'b0;
    mem_wb_flush_o = 1'b0;
    if (!reset_i) begin
      pc_en_o        = 1'b0;
      if_id_en_o     = 1'b0;
      id_ex_en_o     = 1'b0;
      ex_mem_en_o    = 1'b0;
      if_id_flush_o  = 1'b1;
      id_ex_flush_o  = 1'b1;
      mem_wb_flush_o = 1'b1;
    end else begin
      if (r_state == StFlush) begin
        if_id_flush_o = 1'b1;
        id_ex_flush_o = 1'b1;
      end
      if (w_freeze) begin
        pc_en_o        = 1'b0;
        if_id_en_o     = 1'b0;
        id_ex_en_o     = 1'b0;
        ex_mem_en_o    = 1'b0;
        mem_wb_flush_o = 1'b1;
      end else if (r_state == StRun && branch_taken_i) begin
        if_id_flush_o = 1'b1;
        id_ex_flush_o = 1'b1;
      end else if (r_state == StRun && w_lu) begin
        pc_en_o       = 1'b0;
        if_id_en_o    = 1'b0;
        id_ex_flush_o = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      r_state     <= StRun;
      r_pend_br   <= 1'b0;
      r_wait_cnt  <= 8'd0;
      r_stall_cnt <= '0;
      r_mem_err   <= 1'b0;
    end else begin
      if (!pc_en_o && r_stall_cnt != '1) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
      unique case (r_state)
        StRun, StFlush: begin
          if (w_ms) begin
            r_state    <= StMemWait;
            r_pend_br  <= branch_taken_i;
            r_wait_cnt <= 8'd1;
            if (TimeoutVal == 8'd1) r_mem_err <= 1'b1;
          end else begin
            r_state   <= StRun;
            r_pend_br <= 1'b0;
          end
        end
        StMemWait: begin
          if (w_rdy) begin
            r_wait_cnt <= 8'd0;
            r_state    <= r_pend_br ? StFlush : StRun;
          end else begin
            r_wait_cnt <= w_wait_nxt;
            if (branch_taken_i) r_pend_br <= 1'b1;
            if (w_wait_nxt == TimeoutVal) r_mem_err <= 1'b1;
          end
        end
        default: r_state <= StRun;
      endcase
    end
  end

  assign stall_cnt_o = r_stall_cnt;
  assign mem_err_o   = r_mem_err;

endmodule
